bcd2_seg7_scan: RTL and testbench

- Downstream consumer of the two-digit BCD product produced by the BCD multiplier stage.
- Captures the 8-bit packed BCD value (tens in [7:4], units in [3:0]) on a load strobe.
- Drives a two-digit common-anode 7-segment display by time-multiplexing the digits, with a blanking gap between them to suppress ghosting.
- Flags non-BCD input and shows "EE" when it occurs.

---
 rtl/bcd2_seg7_scan_pkg.sv | 24 ++
 rtl/bcd_to_seg7.sv | 33 +++
 rtl/bcd2_seg7_scan.sv | 123 ++++++++++++
 tb/tb_bcd2_seg7_scan.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd2_seg7_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the two-digit BCD 7-segment scanner.
//   state_t   : scan FSM states, in display order
//   SEG_*     : active-low segment patterns {g,f,e,d,c,b,a}
//   AN_*      : active-low anode patterns, an[0]=units, an[1]=tens
// ---------------------------------------------------------------------------
package seg7_pkg;

   typedef enum logic [1:0] {
      SHOW_LO = 2'd0,
      GAP_LO  = 2'd1,
      SHOW_HI = 2'd2,
      GAP_HI  = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   localparam logic [1:0] AN_OFF = 2'b11;
   localparam logic [1:0] AN_LO  = 2'b10;
   localparam logic [1:0] AN_HI  = 2'b01;

endpackage

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD nibble to active-low 7-segment decoder.
// Any nibble above 9 decodes to the "E" glyph.
//   digit : 4-bit BCD input
//   seg   : 7-bit active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Lookup of the digit glyphs; everything outside 0..9 shows "E".
   always_comb begin
      seg = SEG_E;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/bcd2_seg7_scan.sv
// ---------------------------------------------------------------------------
// bcd2_seg7_scan
// Captures a packed two-digit BCD value and drives a two-digit common-anode
// 7-segment display by time multiplexing, with an all-off gap between digit
// slots to suppress ghosting. A non-BCD value shows "EE".
//   clk    : system clock, rising edge
//   rst    : synchronous reset, active-high
//   load   : capture strobe for bcd_in
//   bcd_in : packed BCD, [7:4] tens, [3:0] units
//   seg    : active-low segments {g,f,e,d,c,b,a}, registered
//   an     : active-low anodes, an[0]=units, an[1]=tens, registered
//   err    : high while the held value contains a nibble above 9, registered
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
// ---------------------------------------------------------------------------
module bcd2_seg7_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYCLES  = 8
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] bcd_in,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       err
);

   localparam int CW = $clog2(REFRESH_DIV);

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   limit_m1;
   logic            slot_end;
   logic [7:0]      held;
   logic [3:0]      digit;
   logic [6:0]      dec_seg;
   logic [6:0]      seg_next;
   logic [1:0]      an_next;

   // Slot length depends on whether a digit is lit or the gap is active;
   // the gap is always shorter, so the shared counter never overflows.
   always_comb begin
      limit_m1 = CW'(GAP_CYCLES - 1);
      if (state == SHOW_LO || state == SHOW_HI) begin
         limit_m1 = CW'(REFRESH_DIV - 1);
      end
      slot_end = (cnt == limit_m1);
   end

   // Scan order advances at the end of each slot.
   always_comb begin
      next_state = state;
      if (slot_end) begin
         case (state)
            SHOW_LO: next_state = GAP_LO;
            GAP_LO:  next_state = SHOW_HI;
            SHOW_HI: next_state = GAP_HI;
            default: next_state = SHOW_LO;
         endcase
      end
   end

   // Outputs are decoded from the next state so anode, segments and state
   // all change on the same edge; the gap states guarantee that the two
   // anodes are never driven low together.
   assign digit = (next_state == SHOW_HI) ? held[7:4] : held[3:0];

   bcd_to_seg7 u_dec (
      .digit (digit),
      .seg   (dec_seg)
   );

   always_comb begin
      an_next  = AN_OFF;
      seg_next = SEG_BLANK;
      case (next_state)
         SHOW_LO: begin
            an_next  = AN_LO;
            seg_next = err ? SEG_E : dec_seg;
         end
         SHOW_HI: begin
            an_next  = AN_HI;
            seg_next = err ? SEG_E : dec_seg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (!err && held[7:4] == 4'd0) begin
               seg_next = SEG_BLANK;
            end
`endif
         end
         default: begin
            an_next  = AN_OFF;
            seg_next = SEG_BLANK;
         end
      endcase
   end

   // Capture, scan timing and registered outputs. A load only changes the
   // held value; it never restarts the scan, so a new value shows up one
   // edge later within whatever slot is current.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SHOW_LO;
         cnt   <= '0;
         held  <= 8'h00;
         err   <= 1'b0;
         seg   <= SEG_BLANK;
         an    <= AN_OFF;
      end else begin
         state <= next_state;
         cnt   <= slot_end ? '0 : cnt + CW'(1);
         seg   <= seg_next;
         an    <= an_next;
         if (load) begin
            held <= bcd_in;
            err  <= (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
         end
      end
   end

endmodule

// File: tb/tb_bcd2_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd2_seg7_scan
// Scoreboard bench for bcd2_seg7_scan with a short scan (4-cycle digits,
// 1-cycle gaps). The stimulus side predicts each edge's outputs from the
// position within the scan period and pushes them into a queue; a monitor
// pops and compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_bcd2_seg7_scan;

   localparam int R      = 4;
   localparam int G      = 1;
   localparam int PERIOD = 2 * (R + G);

   typedef struct packed {
      logic [6:0] seg;
      logic [1:0] an;
      logic       err;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] bcd_in;
   logic [6:0] seg;
   logic [1:0] an;
   logic       err;

   exp_t sb_q[$];
   int   pass_cnt;
   int   total_cnt;

   // Reference model state
   logic [7:0] m_held;
   logic       m_err;
   int         m_pos;

   logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

   bcd2_seg7_scan #(
      .REFRESH_DIV (R),
      .GAP_CYCLES  (G)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .bcd_in (bcd_in),
      .seg    (seg),
      .an     (an),
      .err    (err)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] glyph_of(input logic [3:0] d);
      return (d <= 4'd9) ? glyph[d] : 7'b0000110;
   endfunction

   // Drive one cycle of inputs, predict the outputs after the coming edge,
   // then wait for the falling edge.
   task automatic applyStimulus(input logic r, input logic l, input logic [7:0] v);
      exp_t e;
      int   p;
      rst    = r;
      load   = l;
      bcd_in = v;
      if (r) begin
         e      = '{seg: 7'h7F, an: 2'b11, err: 1'b0};
         m_held = 8'h00;
         m_err  = 1'b0;
         m_pos  = 0;
      end else begin
         m_pos = (m_pos + 1) % PERIOD;
         p     = m_pos;
         e.seg = 7'h7F;
         e.an  = 2'b11;
         if (p < R) begin
            e.an  = 2'b10;
            e.seg = m_err ? 7'b0000110 : glyph_of(m_held[3:0]);
         end else if (p >= R + G && p < 2 * R + G) begin
            e.an  = 2'b01;
            e.seg = m_err ? 7'b0000110 : glyph_of(m_held[7:4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (!m_err && m_held[7:4] == 4'd0) e.seg = 7'h7F;
`endif
         end
         if (l) begin
            m_held = v;
            m_err  = (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
         end
         e.err = m_err;
      end
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
   endtask

   // Compare one popped expectation plus the anode safety properties.
   task automatic checkOutput(input exp_t e, input logic [1:0] prev_an);
      check("seg", seg, e.seg);
      check("an", {5'b0, an}, {5'b0, e.an});
      check("err", {6'b0, err}, {6'b0, e.err});
      check("an_not_both_low", {6'b0, (an === 2'b00)}, 7'd0);
      if (prev_an !== 2'b11 && an !== 2'b11) begin
         check("an_gap_between", {5'b0, an}, {5'b0, prev_an});
      end
   endtask

   // Monitor: after every rising edge, pop and compare.
   initial begin
      logic [1:0] prev_an;
      exp_t       e;
      prev_an = 2'b11;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput(e, prev_an);
            prev_an = an;
         end
      end
   end

   initial begin
      logic       r;
      logic       l;
      logic [7:0] v;
      pass_cnt  = 0;
      total_cnt = 0;
      m_held    = 8'h00;
      m_err     = 1'b0;
      m_pos     = 0;

      // Reset held for three edges, then the value 00 scans out
      repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
      idle(12);

      // Ordinary value
      applyStimulus(1'b0, 1'b1, 8'h42);
      idle(20);

      // Invalid value, then recovery on a valid load
      applyStimulus(1'b0, 1'b1, 8'h3A);
      idle(20);
      applyStimulus(1'b0, 1'b1, 8'h81);
      idle(20);

      // Mid-slot load of 99 while 11 is showing
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h11);
      idle(PERIOD - 1);
      applyStimulus(1'b0, 1'b1, 8'h99);
      idle(12);

      // Zero tens digit (blanked only when the optional feature is built)
      applyStimulus(1'b0, 1'b1, 8'h07);
      idle(12);
      applyStimulus(1'b0, 1'b1, 8'h00);
      idle(12);

      // Randomised traffic with occasional resets and invalid values
      for (int i = 0; i < 1000; i++) begin
         r = ($urandom_range(0, 49) == 0);
         l = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) v = 8'($urandom_range(0, 255));
         else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         applyStimulus(r, l, v);
      end

      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         total_cnt++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
